// File: rtl/viterbi_decode.sv
// Hard-decision Viterbi decoder for the K=4, rate-1/2 code (g1 = 1+D^2+D^3, g0 = 1+D+D^2+D^3).
// Frame flow: one ACS per accepted symbol, full-frame traceback from state 0, then in-order bit output.
module viterbi_decode #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 3,
  parameter int PM_W      = 8
) (
  input  logic       clk_sig,
  input  logic       rst_sig,
  input  logic [1:0] sym_sig,
  input  logic       sym_valid_sig,
  output logic       sym_ready_sig,
  output logic       dec_sig,
  output logic       dec_valid_sig,
  output logic       dec_last_sig,
  output logic       busy_sig
);

  localparam int N  = FRAME_LEN + TAIL_LEN;
  localparam int IW = $clog2(N);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0]   FL_IDX   = IW'(FRAME_LEN);
  localparam logic [BW-1:0]   LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0] PM_MAX   = '1;
  localparam logic [PM_W-1:0] PM_HI    = {1'b1, {(PM_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACS    = 2'd1;
  localparam logic [1:0] S_TRACE  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  // Expected {g1,g0} when input u leaves trellis state s = {u_{t-1},u_{t-2},u_{t-3}}.
  function automatic logic [1:0] exp_sym(input logic [2:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[2] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {d[1] & d[0], d[1] ^ d[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  logic [1:0]      r_state;
  logic [IW-1:0]   r_sym_cnt;
  logic [IW-1:0]   r_trc_idx;
  logic [2:0]      r_trc_st;
  logic [BW-1:0]   r_out_cnt;
  logic [PM_W-1:0] r_pm [8];
  logic [7:0]      r_surv [N];
  logic [FRAME_LEN-1:0] r_buf;

  logic [PM_W-1:0] w_pm_src [8];
  logic [PM_W-1:0] w_pm_new [8];
  logic [7:0]      w_dec;
  logic [7:0]      w_surv_row;
  logic            w_surv_bit;
  logic            w_accept;

  assign sym_ready_sig = ~rst_sig & ((r_state == S_IDLE) | (r_state == S_ACS));
  assign w_accept      = sym_valid_sig & sym_ready_sig;

  // The first symbol of a frame always starts from the frame-start metrics.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (r_state == S_IDLE) w_pm_src[i] = (i == 0) ? '0 : PM_HI;
      else                   w_pm_src[i] = r_pm[i];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_acs
    localparam logic [2:0] NS = 3'(g);
    localparam logic [2:0] P0 = {NS[1:0], 1'b0};
    localparam logic [2:0] P1 = {NS[1:0], 1'b1};
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    assign w_c0        = sat_add(w_pm_src[P0], hamming(sym_sig, exp_sym(P0, NS[2])));
    assign w_c1        = sat_add(w_pm_src[P1], hamming(sym_sig, exp_sym(P1, NS[2])));
    // Strict compare: equal metrics keep the predecessor whose LSB is 0.
    assign w_dec[g]    = (w_c1 < w_c0);
    assign w_pm_new[g] = w_dec[g] ? w_c1 : w_c0;
  end

  assign w_surv_row = r_surv[r_trc_idx];
  assign w_surv_bit = w_surv_row[r_trc_st];

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      r_state   <= S_IDLE;
      r_sym_cnt <= '0;
      r_trc_idx <= LAST_IDX;
      r_trc_st  <= '0;
      r_out_cnt <= '0;
      for (int i = 0; i < 8; i++) r_pm[i] <= (i == 0) ? '0 : PM_HI;
    end else begin
      case (r_state)
        S_IDLE, S_ACS: begin
          if (w_accept) begin
            for (int i = 0; i < 8; i++) r_pm[i] <= w_pm_new[i];
            if (r_sym_cnt == LAST_IDX) begin
              r_state   <= S_TRACE;
              r_sym_cnt <= '0;
              r_trc_idx <= LAST_IDX;
              r_trc_st  <= '0;
            end else begin
              r_state   <= S_ACS;
              r_sym_cnt <= r_sym_cnt + 1'b1;
            end
          end
        end
        S_TRACE: begin
          r_trc_st <= {r_trc_st[1:0], w_surv_bit};
          if (r_trc_idx == '0) begin
            r_state   <= S_OUTPUT;
            r_out_cnt <= '0;
          end else begin
            r_trc_idx <= r_trc_idx - 1'b1;
          end
        end
        default: begin
          if (r_out_cnt == LAST_BIT) r_state   <= S_IDLE;
          else                       r_out_cnt <= r_out_cnt + 1'b1;
        end
      endcase
    end
  end

  // Survivor and output storage carry no reset; a reset frame is simply never read.
  always_ff @(posedge clk_sig) begin
    if (w_accept) r_surv[r_sym_cnt] <= w_dec;
    if ((r_state == S_TRACE) && (r_trc_idx < FL_IDX)) r_buf[r_trc_idx[BW-1:0]] <= r_trc_st[2];
  end

  assign dec_valid_sig = (r_state == S_OUTPUT);
  assign dec_sig       = dec_valid_sig & r_buf[r_out_cnt];
  assign dec_last_sig  = dec_valid_sig & (r_out_cnt == LAST_BIT);
  assign busy_sig      = (r_state != S_IDLE);

endmodule

// File: tb/tb_viterbi_decode.sv
// Bench for viterbi_decode: a frame-level reference (convolutional encoder plus path-register
// Viterbi and a fixed occupancy timeline) predicts every output cycle by cycle.
module tb_viterbi_decode;
  localparam int FL = 64;
  localparam int N  = FL + 3;

  logic       clk_sig = 1'b0;
  logic       rst_sig = 1'b1;
  logic [1:0] sym_sig = 2'b00;
  logic       sym_valid_sig = 1'b0;
  logic       sym_ready_sig;
  logic       dec_sig;
  logic       dec_valid_sig;
  logic       dec_last_sig;
  logic       busy_sig;

  viterbi_decode #(.FRAME_LEN(FL), .TAIL_LEN(3), .PM_W(8)) dut (
    .clk_sig       (clk_sig),
    .rst_sig       (rst_sig),
    .sym_sig       (sym_sig),
    .sym_valid_sig (sym_valid_sig),
    .sym_ready_sig (sym_ready_sig),
    .dec_sig       (dec_sig),
    .dec_valid_sig (dec_valid_sig),
    .dec_last_sig  (dec_last_sig),
    .busy_sig      (busy_sig)
  );

  always #5 clk_sig = ~clk_sig;

  int n_err = 0;
  int n_chk = 0;

  // Reference-side bookkeeping, advanced once per rising edge.
  int cyc = 0;
  int m_cnt = 0;
  int m_block = 0;
  int m_acc_total = 0;
  int m_last_acc = -1000;
  int exp_base = 0;
  bit exp_active = 0;
  logic [2*N-1:0] m_syms = '0;
  logic [FL-1:0]  exp_bits = '0;

  function automatic logic [2*N-1:0] encode(input logic [FL-1:0] info);
    logic [2*N-1:0] s;
    bit u, u1, u2, u3;
    s = '0; u1 = 0; u2 = 0; u3 = 0;
    for (int t = 0; t < N; t++) begin
      u = (t < FL) ? info[t] : 1'b0;
      s[2*t+1] = u ^ u2 ^ u3;
      s[2*t]   = u ^ u1 ^ u2 ^ u3;
      u3 = u2; u2 = u1; u1 = u;
    end
    return s;
  endfunction

  // Register-exchange Viterbi: each state keeps its whole surviving input sequence.
  function automatic logic [FL-1:0] vit_model(input logic [2*N-1:0] s);
    int pm[8];
    int npm[8];
    logic [N-1:0] path[8];
    logic [N-1:0] npath[8];
    logic [1:0] rx;
    logic [1:0] e;
    int u, p, bp, cost, best;
    for (int i = 0; i < 8; i++) begin
      pm[i] = (i == 0) ? 0 : 128;
      path[i] = '0;
    end
    for (int t = 0; t < N; t++) begin
      rx = s[2*t +: 2];
      for (int ns = 0; ns < 8; ns++) begin
        u = (ns >> 2) & 1;
        best = -1; bp = 0;
        for (int c = 0; c < 2; c++) begin
          p = ((ns & 3) << 1) | c;
          e[1] = 1'(u ^ ((p >> 1) & 1) ^ (p & 1));
          e[0] = 1'(u ^ ((p >> 2) & 1) ^ ((p >> 1) & 1) ^ (p & 1));
          cost = pm[p] + $countones(rx ^ e);
          if (cost > 255) cost = 255;
          if (best < 0 || cost < best) begin
            best = cost; bp = p;
          end
        end
        npm[ns] = best;
        npath[ns] = path[bp];
        npath[ns][t] = 1'(u);
      end
      for (int i = 0; i < 8; i++) begin
        pm[i] = npm[i];
        path[i] = npath[i];
      end
    end
    return path[0][FL-1:0];
  endfunction

  always @(posedge clk_sig) begin
    if (rst_sig) begin
      m_cnt = 0; m_block = 0; exp_active = 0;
    end else if (m_block > 0) begin
      m_block--;
    end else if (sym_valid_sig) begin
      m_syms[2*m_cnt +: 2] = sym_sig;
      m_cnt++; m_acc_total++; m_last_acc = cyc;
      if (m_cnt == N) begin
        exp_bits = vit_model(m_syms);
        exp_base = cyc + N + 1;
        exp_active = 1;
        m_block = N + FL;
        m_cnt = 0;
      end
    end
    cyc++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_frame(input logic [2*N-1:0] s, input int nsyms, input int gap_pct, input bit keep);
    int i, prev;
    i = 0;
    while (i < nsyms) begin
      if (m_block == 0 && $urandom_range(99) >= gap_pct) begin
        sym_valid_sig = 1'b1;
        sym_sig = s[2*i +: 2];
      end else begin
        sym_valid_sig = keep && (m_block > 0);
        sym_sig = 2'($urandom);
      end
      prev = m_acc_total;
      @(posedge clk_sig); #1;
      if (m_acc_total != prev) i++;
    end
    if (!keep) sym_valid_sig = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((m_block > 0 || m_cnt > 0) && g < 1000) begin
      @(posedge clk_sig); g++;
    end
    repeat (2) @(posedge clk_sig);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_sig); #3;
    rst_sig = 1'b1;
    repeat (2) @(posedge clk_sig);
    #3;
    rst_sig = 1'b0;
  endtask

  function automatic logic [2*N-1:0] flip(input logic [2*N-1:0] s, input int nflips);
    logic [2*N-1:0] r;
    r = s;
    for (int k = 0; k < nflips; k++) begin
      int b;
      b = $urandom_range(2*N-1);
      r[b] = ~r[b];
    end
    return r;
  endfunction

  initial begin
    fork
      begin : compare_proc
        bit prev_v;
        bit ev;
        int k;
        prev_v = 0;
        forever begin
          @(negedge clk_sig or posedge rst_sig);
          #1;
          if (rst_sig) begin
            check("rst_ready", sym_ready_sig, 0);
            check("rst_valid", dec_valid_sig, 0);
            check("rst_dec",   dec_sig, 0);
            check("rst_last",  dec_last_sig, 0);
            check("rst_busy",  busy_sig, 0);
            prev_v = 0;
          end else begin
            ev = exp_active && (cyc >= exp_base) && (cyc < exp_base + FL);
            k  = cyc - exp_base;
            check("ready", sym_ready_sig, (m_block == 0));
            check("busy",  busy_sig, (m_cnt > 0 || m_block > 0));
            check("valid", dec_valid_sig, ev);
            check("dec",   dec_sig, ev ? exp_bits[k] : 1'b0);
            check("last",  dec_last_sig, ev && (k == FL - 1));
            if (dec_valid_sig && !prev_v) check("latency", cyc - m_last_acc, 68);
            prev_v = dec_valid_sig;
          end
        end
      end
      begin : main_proc
        logic [FL-1:0]  info;
        logic [FL-1:0]  info2;
        logic [2*N-1:0] s;
        int p1, p2;

        repeat (3) @(posedge clk_sig);
        #3;
        rst_sig = 1'b0;

        s = encode(64'h1);
        check("enc_impulse", s[9:0], 10'b0011110111);
        check("enc_impulse_rest", s[2*N-1:10], 0);
        check("model_impulse", vit_model(s), 64'h1);
        check("model_zero", vit_model(encode('0)), 0);

        drive_frame(encode('0), N, 0, 0);
        wait_done();
        drive_frame(encode(64'h1), N, 0, 0);
        wait_done();

        for (int r = 0; r < 3; r++) begin
          info = {$urandom, $urandom};
          s = flip(encode(info), 1);
          check("model_1err", vit_model(s), info);
          drive_frame(s, N, 0, 0);
          wait_done();
        end

        for (int r = 0; r < 3; r++) begin
          info = {$urandom, $urandom};
          s = encode(info);
          p1 = $urandom_range(2*N - 41);
          p2 = p1 + 2 * (12 + $urandom_range(7));
          s[p1] = ~s[p1];
          s[p2] = ~s[p2];
          check("model_2err", vit_model(s), info);
          drive_frame(s, N, 0, 0);
          wait_done();
        end

        for (int r = 0; r < 2; r++) begin
          info = {$urandom, $urandom};
          drive_frame(flip(encode(info), r), N, 40, 0);
          wait_done();
        end

        info = {$urandom, $urandom};
        drive_frame(encode(info), 30, 0, 0);
        do_reset();
        drive_frame(encode(info), N, 0, 0);
        wait_done();

        info = {$urandom, $urandom};
        drive_frame(encode(info), N, 0, 0);
        p1 = 0;
        while (cyc < exp_base + 10 && p1 < 500) begin
          @(posedge clk_sig); p1++;
        end
        do_reset();
        info = {$urandom, $urandom};
        drive_frame(encode(info), N, 0, 0);
        wait_done();

        info  = {$urandom, $urandom};
        info2 = {$urandom, $urandom};
        drive_frame(encode(info), N, 0, 1);
        drive_frame(encode(info2), N, 0, 1);
        sym_valid_sig = 1'b0;
        wait_done();

        for (int r = 0; r < 3; r++) begin
          info = {$urandom, $urandom};
          drive_frame(flip(encode(info), 6), N, 10, 0);
          wait_done();
        end

        repeat (5) @(posedge clk_sig);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
      end
    join_any
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
